// File: rtl/exp_table_reader.sv
// exp_table_reader: stores the exp(x*sigma) table streamed in by the generator and
// answers clamped, optionally interpolated lookups. Interpolation: define EXP_READER_INTERP_EN.
module exp_table_reader #(
  parameter int x_min     = -307,
  parameter int x_max     = 280,
  parameter int pathWidth = 10,
  parameter int FRAC      = 4
) (
  input  logic                      CLK,
  input  logic                      iRst_n,
  input  logic                      iWrEn,
  input  logic [pathWidth-1:0]      iWrAddr,
  input  logic [17:0]               iWrData,
  input  logic                      iWrDone,
  input  logic                      iReq,
  input  logic [pathWidth+FRAC-1:0] iX,
  output logic [17:0]               oData,
  output logic                      oValid,
  output logic                      oBusy,
  output logic                      oReady
);

  localparam int XW    = pathWidth + FRAC;
  localparam int DEPTH = 2 ** pathWidth;

  localparam logic signed [pathWidth-1:0] XMIN = pathWidth'(x_min);
  localparam logic signed [pathWidth-1:0] XMAX = pathWidth'(x_max);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TBL,
    RD0,
    RD1,
    CALC,
    OUT
  } state_t;

  state_t                 r_state;
  logic [17:0]            r_mem [DEPTH];
  logic [17:0]            r_rd_data;
  logic [pathWidth-1:0]   r_idx;
  logic [17:0]            r_y0;
  logic [17:0]            r_res;

  logic signed [pathWidth-1:0] w_x_int;
  logic [pathWidth-1:0]        w_idx;
  logic [pathWidth-1:0]        w_rd_addr;
  logic [17:0]                 w_result;

  // Clamp the query at accept time so the read stages only see a legal index.
  // NOTE: every signal written in always_comb gets a default first, or a latch is inferred.
  always_comb begin
    w_x_int = iX[XW-1:FRAC];
    w_idx   = w_x_int;
    if (w_x_int < XMIN) begin
      w_idx = XMIN;
    end else if (w_x_int >= XMAX) begin
      w_idx = XMAX;
    end
  end

  assign w_rd_addr = (r_state == RD1) ? r_idx + pathWidth'(1) : r_idx;

  // NOTE: table RAM has no reset; the generator always rewrites it before oReady is set.
  always_ff @(posedge CLK) begin
    if (iWrEn) begin
      r_mem[iWrAddr] <= iWrData;
    end
    r_rd_data <= r_mem[w_rd_addr];
  end

`ifdef EXP_READER_INTERP_EN
  localparam int PW = 19 + FRAC + 1;

  logic [FRAC-1:0]          r_frac;
  logic [FRAC-1:0]          w_frac;
  logic signed [18:0]       w_diff;
  logic signed [PW-1:0]     w_prod;
  logic signed [PW-FRAC-1:0] w_sum;

  // Fraction is dropped whenever the integer part had to be clamped.
  always_comb begin
    w_frac = iX[FRAC-1:0];
    if ((w_x_int < XMIN) || (w_x_int >= XMAX)) begin
      w_frac = '0;
    end
  end

  // y1 arrives on r_rd_data during CALC; p >>> FRAC floors toward -inf.
  always_comb begin
    w_diff   = signed'({1'b0, r_rd_data}) - signed'({1'b0, r_y0});
    w_prod   = signed'({{(FRAC + 1){w_diff[18]}}, w_diff}) * signed'({{(PW - FRAC){1'b0}}, r_frac});
    w_sum    = signed'({{(PW - FRAC - 18){1'b0}}, r_y0}) + w_prod[PW-1:FRAC];
    w_result = w_sum[17:0];
  end

  always_ff @(posedge CLK or negedge iRst_n) begin
    if (!iRst_n) begin
      r_frac <= '0;
    end else if ((r_state == IDLE) && iReq) begin
      r_frac <= w_frac;
    end
  end
`else
  logic w_unused_frac;

  assign w_unused_frac = ^iX[FRAC-1:0];
  assign w_result      = r_y0;
`endif

  // Table-valid flag: a done pulse wins over a simultaneous write.
  always_ff @(posedge CLK or negedge iRst_n) begin
    if (!iRst_n) begin
      oReady <= 1'b0;
    end else if (iWrDone) begin
      oReady <= 1'b1;
    end else if (iWrEn) begin
      oReady <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_y0    <= '0;
      r_res   <= '0;
      oData   <= '0;
      oValid  <= 1'b0;
      oBusy   <= 1'b0;
    end else begin
      oValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (iReq) begin
            r_idx   <= w_idx;
            oBusy   <= 1'b1;
            r_state <= oReady ? RD0 : WAIT_TBL;
          end
        end
        WAIT_TBL: begin
          if (oReady) begin
            r_state <= RD0;
          end
        end
        RD0: begin
          r_state <= RD1;
        end
        RD1: begin
          r_y0    <= r_rd_data;
          r_state <= CALC;
        end
        CALC: begin
          r_res   <= w_result;
          r_state <= OUT;
        end
        OUT: begin
          oData   <= r_res;
          oValid  <= 1'b1;
          oBusy   <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exp_table_reader.sv
// Self-checking bench for exp_table_reader: directed vector table, table-wait and
// multi-cycle corner cases, plus randomized lookups against an arithmetic model.
module tb_exp_table_reader;

  logic        CLK = 1'b0;
  logic        iRst_n;
  logic        iWrEn;
  logic [9:0]  iWrAddr;
  logic [17:0] iWrData;
  logic        iWrDone;
  logic        iReq;
  logic [13:0] iX;
  logic [17:0] oData;
  logic        oValid;
  logic        oBusy;
  logic        oReady;

  exp_table_reader dut (
    .CLK     (CLK),
    .iRst_n  (iRst_n),
    .iWrEn   (iWrEn),
    .iWrAddr (iWrAddr),
    .iWrData (iWrData),
    .iWrDone (iWrDone),
    .iReq    (iReq),
    .iX      (iX),
    .oData   (oData),
    .oValid  (oValid),
    .oBusy   (oBusy),
    .oReady  (oReady)
  );

  always #5 CLK = ~CLK;

`ifdef EXP_READER_INTERP_EN
  localparam bit INTERP = 1'b1;
`else
  localparam bit INTERP = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int model_mem [1024];

  typedef struct {
    int          xi;
    int          xf;
    logic [17:0] exp_interp;
    logic [17:0] exp_floor;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [13:0] mk_x(input int xi, input int xf);
    logic [9:0] ip;
    logic [3:0] fp;
    ip = 10'(xi);
    fp = 4'(xf);
    return {ip, fp};
  endfunction

  // Reference lookup straight from the table rules, using integer arithmetic.
  function automatic logic [17:0] ref_lookup(input logic [13:0] x);
    logic signed [9:0] ip;
    int i, f, y0, y1, num, q;
    ip = x[13:4];
    i  = ip;
    f  = INTERP ? int'(x[3:0]) : 0;
    if (i < -307) begin
      i = -307; f = 0;
    end else if (i >= 280) begin
      i = 280; f = 0;
    end
    y0  = model_mem[i & 1023];
    y1  = model_mem[(i + 1) & 1023];
    num = (y1 - y0) * f;
    q   = num / 16;
    if ((num < 0) && (num % 16 != 0)) q = q - 1;
    return 18'(y0 + q);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int addr, input int data);
    iWrEn   = 1'b1;
    iWrAddr = 10'(addr);
    iWrData = 18'(data);
    tick();
    iWrEn   = 1'b0;
    model_mem[addr & 1023] = data & 18'h3FFFF;
  endtask

  task automatic pulse_done();
    iWrDone = 1'b1;
    tick();
    iWrDone = 1'b0;
  endtask

  // Waits a bounded number of edges for oValid; lat = 0 means it never came.
  task automatic wait_valid(output logic [17:0] data, output int lat);
    lat  = 0;
    data = 'x;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (oValid) begin
        lat  = k;
        data = oData;
        break;
      end
    end
  endtask

  task automatic run_query(input logic [13:0] x, output logic [17:0] data, output int lat);
    iReq = 1'b1;
    iX   = x;
    tick();
    iReq = 1'b0;
    wait_valid(data, lat);
  endtask

  initial begin
    logic [17:0] got;
    logic [13:0] x;
    int          lat;
    int          nvalid;
    int          vpos [$];

    vecs[0] = '{0,    8,  18'h09000, 18'h08000};
    vecs[1] = '{5,    1,  18'h09E00, 18'h0A000};
    vecs[2] = '{0,    0,  18'h08000, 18'h08000};
    vecs[3] = '{-400, 5,  18'h12345, 18'h12345};
    vecs[4] = '{300,  9,  18'h2ABCD, 18'h2ABCD};
    vecs[5] = '{280,  15, 18'h2ABCD, 18'h2ABCD};
    vecs[6] = '{-307, 0,  18'h12345, 18'h12345};

    iRst_n = 1'b0; iWrEn = 1'b0; iWrAddr = '0; iWrData = '0;
    iWrDone = 1'b0; iReq = 1'b0; iX = '0;
    #1;
    check("rst_data",  32'(oData),  32'h0);
    check("rst_valid", 32'(oValid), 32'h0);
    check("rst_busy",  32'(oBusy),  32'h0);
    check("rst_ready", 32'(oReady), 32'h0);
    #21 iRst_n = 1'b1;
    tick();

    // Query before any table: must wait, then finish 5 edges after the done edge.
    wr(0, 'h08000);
    wr(1, 'h0A000);
    iReq = 1'b1; iX = mk_x(0, 8);
    tick();
    iReq = 1'b0;
    check("wait_busy", 32'(oBusy), 32'h1);
    nvalid = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (oValid) nvalid++;
    end
    check("wait_no_valid", 32'(nvalid), 32'h0);
    pulse_done();
    check("done_ready", 32'(oReady), 32'h1);
    wait_valid(got, lat);
    check("wait_latency", 32'(lat), 32'd5);
    check("wait_data", 32'(got), 32'(ref_lookup(mk_x(0, 8))));

    // Rewriting drops oReady on the first write edge; a query then waits again.
    wr(5, 'h0A000);
    check("rewrite_ready", 32'(oReady), 32'h0);
    wr(6, 'h08000);
    wr(-307, 'h12345);
    wr(280, 'h2ABCD);
    wr(281, 'h3FFFF);
    iReq = 1'b1; iX = mk_x(5, 1);
    tick();
    iReq = 1'b0;
    nvalid = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (oValid) nvalid++;
    end
    check("rewrite_wait", 32'(nvalid + (oBusy ? 0 : 10)), 32'h0);
    pulse_done();
    wait_valid(got, lat);
    check("rewrite_data", 32'(got), 32'(INTERP ? 18'h09E00 : 18'h0A000));

    foreach (vecs[v]) begin
      run_query(mk_x(vecs[v].xi, vecs[v].xf), got, lat);
      check($sformatf("vec%0d_lat", v), 32'(lat), 32'd4);
      check($sformatf("vec%0d_data", v), 32'(got),
            32'(INTERP ? vecs[v].exp_interp : vecs[v].exp_floor));
    end

    // Fresh random table over the generator's x range.
    for (int a = -307; a <= 280; a++) begin
      wr(a, int'($urandom_range(0, 18'h3FFFF)));
    end
    pulse_done();
    for (int n = 0; n < 40; n++) begin
      x = 14'($urandom_range(0, 16383));
      run_query(x, got, lat);
      check($sformatf("rand%0d_lat", n), 32'(lat), 32'd4);
      check($sformatf("rand%0d_x%h", n, x), 32'(got), 32'(ref_lookup(x)));
    end

    // iReq held for 10 edges: accepts at edges 0 and 5 only.
    iReq = 1'b1; iX = mk_x(-1, 3);
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 9) iReq = 1'b0;
      if (oValid) begin
        vpos.push_back(k);
        check($sformatf("b2b_data%0d", k), 32'(oData), 32'(ref_lookup(mk_x(-1, 3))));
      end
    end
    check("b2b_count", 32'(vpos.size()), 32'd2);
    if (vpos.size() == 2) check("b2b_spacing", 32'(vpos[1] - vpos[0]), 32'd5);

    // Asynchronous reset in the middle of a query.
    iReq = 1'b1; iX = mk_x(10, 2);
    tick();
    iReq = 1'b0;
    tick();
    #2 iRst_n = 1'b0;
    #1;
    check("mid_rst_data",  32'(oData),  32'h0);
    check("mid_rst_valid", 32'(oValid), 32'h0);
    check("mid_rst_busy",  32'(oBusy),  32'h0);
    check("mid_rst_ready", 32'(oReady), 32'h0);
    #3 iRst_n = 1'b1;
    nvalid = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (oValid || oBusy || oReady) nvalid++;
    end
    check("post_rst_quiet", 32'(nvalid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
